uart_boot_loader: RTL and testbench

Serial boot loader that fills the data-memory write port from a UART stream before the processor runs. It receives 8N1 bytes on `rxd`, assembles them into 24-bit words, and writes them to consecutive addresses on the `dpdmem` write port. It holds the processor in reset until the load completes. It sits upstream of `dpdmem` and `proc` in `soc`, and owns `dwaddr`/`dwdata`/`wen` while `proc_rst` is high.

---
 rtl/uart_boot_loader_if.sv | 10 +
 rtl/uart_boot_loader.sv | 164 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Data-memory write port driven by the UART boot loader.
// The master drives address, data and strobe; the memory side observes them.
interface uart_boot_loader_if;
  logic [23:0] waddr;
  logic [23:0] wdata;
  logic        wen;

  modport master (output waddr, output wdata, output wen);
  modport slave  (input  waddr, input  wdata, input  wen);
endinterface

// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: receives a length header followed by 24-bit words and
// writes them to consecutive memory addresses, holding the processor in reset until done.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WORDS        = 2048
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 rxd,
  uart_boot_loader_if.master   wr,
  output logic                 proc_rst,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [23:0]   MAX_LEN   = 24'(WORDS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {L_HDR, L_LOAD, L_DONE, L_ERR} ld_state_e;

  logic [1:0]    sync_q;
  logic          line_prev_q;
  rx_state_e     rx_st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic [1:0]    bcnt_q;
  logic [15:0]   part_q;
  ld_state_e     ld_st_q;
  logic [23:0]   len_q;
  logic [23:0]   waddr_q;
  logic [23:0]   wdata_q;
  logic          wen_q;
  logic          proc_rst_q;
  logic          done_q;
  logic          err_q;

  logic          rx_line;
  logic          stop_tick_c;
  logic          byte_ok_c;
  logic          frame_err_c;
  logic [23:0]   word_c;

  assign rx_line     = sync_q[1];
  assign stop_tick_c = (rx_st_q == R_STOP) && (cnt_q == BIT_LAST);
  assign byte_ok_c   = stop_tick_c && rx_line;
  assign frame_err_c = stop_tick_c && !rx_line;
  assign word_c      = {sh_q, part_q};

  // Synchronizer resets low so a line held low across reset release never looks like an edge.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b00;
      line_prev_q <= 1'b0;
      rx_st_q     <= R_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      sh_q        <= 8'd0;
      bcnt_q      <= 2'd0;
      part_q      <= 16'd0;
      ld_st_q     <= L_HDR;
      len_q       <= 24'd0;
      waddr_q     <= 24'd0;
      wdata_q     <= 24'd0;
      wen_q       <= 1'b0;
      proc_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      line_prev_q <= rx_line;
      wen_q       <= 1'b0;

      case (rx_st_q)
        R_IDLE: begin
          if (line_prev_q && !rx_line) begin
            rx_st_q <= R_START;
            cnt_q   <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            rx_st_q <= rx_line ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            sh_q  <= {rx_line, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_st_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == BIT_LAST) rx_st_q <= R_IDLE;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
      endcase

      // Byte assembly and header/word handling while the load is still open.
      if (ld_st_q == L_HDR || ld_st_q == L_LOAD) begin
        if (frame_err_c) begin
          ld_st_q <= L_ERR;
          err_q   <= 1'b1;
        end else if (byte_ok_c) begin
          case (bcnt_q)
            2'd0: begin
              part_q[7:0] <= sh_q;
              bcnt_q      <= 2'd1;
            end
            2'd1: begin
              part_q[15:8] <= sh_q;
              bcnt_q       <= 2'd2;
            end
            default: begin
              bcnt_q <= 2'd0;
              if (ld_st_q == L_HDR) begin
                if (word_c == 24'd0 || word_c > MAX_LEN) begin
                  ld_st_q <= L_ERR;
                  err_q   <= 1'b1;
                end else begin
                  len_q   <= word_c;
                  waddr_q <= 24'd0;
                  ld_st_q <= L_LOAD;
                end
              end else begin
                wdata_q <= word_c;
                wen_q   <= 1'b1;
              end
            end
          endcase
        end
      end

      // Address advances after each write; the last write closes the load.
      if (wen_q) begin
        if (waddr_q == len_q - 24'd1) begin
          ld_st_q    <= L_DONE;
          done_q     <= 1'b1;
          proc_rst_q <= 1'b0;
        end else begin
          waddr_q <= waddr_q + 24'd1;
        end
      end
    end
  end

  assign wr.waddr = waddr_q;
  assign wr.wdata = wdata_q;
  assign wr.wen   = wen_q;
  assign proc_rst = proc_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a byte-level reference model predicts
// memory writes and final status; a monitor compares each wen against the queue.
module tb_uart_boot_loader;

  localparam int unsigned CLKS  = 8;
  localparam int unsigned WORDS = 16;

  typedef struct {
    logic [7:0] b;
    bit         ok;
  } rx_byte_t;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  logic rxd    = 1'b1;
  logic proc_rst, done, err;

  uart_boot_loader_if wr ();

  uart_boot_loader #(.CLKS_PER_BIT(CLKS), .WORDS(WORDS)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .rxd      (rxd),
    .wr       (wr),
    .proc_rst (proc_rst),
    .done     (done),
    .err      (err)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];
  bit exp_done, exp_err;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the byte stream, groups bytes into little-endian words.
  task automatic model(input rx_byte_t s[$]);
    int n = 0, addr = 0, k = 0;
    bit hdr = 1'b1;
    logic [23:0] w = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    foreach (s[i]) begin
      if (exp_done || exp_err) continue;
      if (!s[i].ok) begin
        exp_err = 1'b1;
        continue;
      end
      w[8*k +: 8] = s[i].b;
      k++;
      if (k == 3) begin
        k = 0;
        if (hdr) begin
          if (w == 0 || int'(w) > WORDS) exp_err = 1'b1;
          else begin
            n   = int'(w);
            hdr = 1'b0;
          end
        end else begin
          exp_q.push_back({24'(addr), w});
          addr++;
          if (addr == n) exp_done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CLKS) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(ok ? 1'b1 : 1'b0);
  endtask

  task automatic add_word(inout rx_byte_t s[$], input logic [23:0] w);
    for (int i = 0; i < 3; i++) s.push_back('{b: w[8*i +: 8], ok: 1'b1});
  endtask

  task automatic run(input string tag, input rx_byte_t s[$]);
    model(s);
    foreach (s[i]) send_byte(s[i].b, s[i].ok);
    rxd = 1'b1;
    repeat (6 * CLKS) @(negedge sysclk);
    chk({tag, "_pending_writes"}, 48'(exp_q.size()), 48'd0);
    chk({tag, "_done"}, 48'(done), 48'(exp_done));
    chk({tag, "_err"}, 48'(err), 48'(exp_err));
    chk({tag, "_proc_rst"}, 48'(proc_rst), 48'(!exp_done));
  endtask

  task automatic do_reset(input logic line);
    @(negedge sysclk);
    rst = 1'b1;
    rxd = line;
    repeat (3) @(negedge sysclk);
    #1;
    chk("rst_waddr", 48'(wr.waddr), 48'd0);
    chk("rst_wdata", 48'(wr.wdata), 48'd0);
    chk("rst_wen", 48'(wr.wen), 48'd0);
    chk("rst_proc_rst", 48'(proc_rst), 48'd1);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_err", 48'(err), 48'd0);
    exp_q.delete();
    @(negedge sysclk);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);
  endtask

  // Monitor: compare every write strobe against the scoreboard, and done timing.
  logic wen_prev = 1'b0, done_prev = 1'b0;
  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      if (!rst) begin
        if (wr.wen === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wen addr=%0h data=%0h expected=no write", wr.waddr, wr.wdata);
          end else begin
            chk("write_addr_data", {wr.waddr, wr.wdata}, exp_q.pop_front());
          end
        end
        if (done === 1'b1 && done_prev === 1'b0)
          chk("done_follows_last_wen", 48'(wen_prev), 48'd1);
      end
      wen_prev  = wr.wen;
      done_prev = done;
    end
  end

  initial begin
    rx_byte_t s[$];
    int n;
    do_reset(1'b1);

    // Reference load from the plan, with trailing bytes that must be ignored.
    s = {};
    add_word(s, 24'd3);
    add_word(s, 24'h123456);
    add_word(s, 24'h789ABC);
    add_word(s, 24'h000001);
    add_word(s, 24'($urandom));
    run("plan_load", s);

    // Random-length random-data load.
    do_reset(1'b1);
    s = {};
    n = $urandom_range(1, 8);
    add_word(s, 24'(n));
    for (int i = 0; i < n; i++) add_word(s, 24'($urandom));
    run("rand_load", s);

    // Framing error after a valid header.
    do_reset(1'b1);
    s = {};
    add_word(s, 24'd2);
    s.push_back('{b: 8'($urandom), ok: 1'b0});
    run("framing", s);

    // Glitch on the idle line, then a one-word load.
    do_reset(1'b1);
    rxd = 1'b0;
    repeat (2) @(negedge sysclk);
    rxd = 1'b1;
    repeat (3 * CLKS) @(negedge sysclk);
    s = {};
    add_word(s, 24'd1);
    add_word(s, 24'hCCBBAA);
    run("glitch", s);

    // Header boundaries.
    do_reset(1'b1);
    s = {};
    add_word(s, 24'd0);
    add_word(s, 24'h000005);
    run("hdr_zero", s);

    do_reset(1'b1);
    s = {};
    add_word(s, 24'd17);
    add_word(s, 24'h000005);
    run("hdr_17", s);

    do_reset(1'b1);
    s = {};
    add_word(s, 24'h010000 | 24'($urandom_range(0, 15)));
    add_word(s, 24'h000005);
    run("hdr_upper", s);

    do_reset(1'b1);
    s = {};
    add_word(s, 24'd16);
    for (int i = 0; i < 16; i++) add_word(s, 24'($urandom));
    run("hdr_16", s);

    // Reset released with the line low must not start a byte.
    do_reset(1'b0);
    repeat (2 * CLKS) @(negedge sysclk);
    rxd = 1'b1;
    repeat (2 * CLKS) @(negedge sysclk);
    s = {};
    add_word(s, 24'd1);
    add_word(s, 24'($urandom));
    run("low_release", s);

    // Reset in the middle of the second data word, then reload.
    do_reset(1'b1);
    s = {};
    add_word(s, 24'd3);
    add_word(s, 24'($urandom));
    s.push_back('{b: 8'($urandom), ok: 1'b1});
    model(s);
    foreach (s[i]) send_byte(s[i].b, s[i].ok);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    chk("midload_pending_writes", 48'(exp_q.size()), 48'd0);
    chk("midload_done", 48'(done), 48'd0);
    do_reset(1'b1);
    s = {};
    add_word(s, 24'd1);
    add_word(s, 24'h000007);
    run("reload", s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
